// File: rtl/regfile_write_bank_pkg.sv
// Shared constants and FSM encoding for the register-file write bank.
package regfile_write_bank_pkg;

    localparam int REG_WIDTH  = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;
    localparam int ZERO_REG   = 0;

    // Write-buffer state: IDLE accepts a write, HOLD commits the latched one.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } wb_state_e;

endpackage

// File: rtl/regfile_write_bank_decoder5to32.sv
// Address-to-one-hot decoder. The zero register's line is forced low so a
// write to it never enables anything; mirrors the read-side word selector.
module decoder5to32
    import regfile_write_bank_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic [ADDR_W-1:0]      addr_i,
    input  logic                   en_i,
    output logic [(1<<ADDR_W)-1:0] onehot_o
);

    // One-hot decode of addr_i, gated by en_i, with the zero register masked.
    always_comb begin
        // NOTE: default every output first so no path leaves it unassigned (no latch).
        onehot_o = '0;
        if (en_i) begin
            onehot_o[addr_i] = 1'b1;
        end
        onehot_o[ZERO_REG] = 1'b0;
    end

endmodule

// File: rtl/regfile_write_bank.sv
// Write side of the CPU register file: optional one-deep write buffer,
// one-hot commit decode, the register array and its flat export bus.
module regfile_write_bank
    import regfile_write_bank_pkg::*;
#(
    parameter int WIDTH      = REG_WIDTH,
    parameter int DEPTH_LOG2 = REG_ADDR_W,
    parameter bit BUFFERED   = 1'b1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              wr_valid,
    output logic                              wr_ready,
    input  logic [DEPTH_LOG2-1:0]             wr_addr,
    input  logic [WIDTH-1:0]                  wr_data,
    output logic [(1<<DEPTH_LOG2)-1:0]        wr_enables,
    output logic [WIDTH*(1<<DEPTH_LOG2)-1:0]  regs_flat,
    output logic                              busy
);

    localparam int NUM = 1 << DEPTH_LOG2;

    // Write that reaches the array on the coming edge.
    logic                  commit_valid;
    logic [DEPTH_LOG2-1:0] commit_addr;
    logic [WIDTH-1:0]      commit_data;
    logic [NUM-1:0]        commit_onehot;

    logic [WIDTH-1:0]      regs_q [NUM];
    logic [NUM-1:0]        wr_enables_q;

    if (BUFFERED) begin : g_buf
        wb_state_e             state_q, state_d;
        logic [DEPTH_LOG2-1:0] addr_q, addr_d;
        logic [WIDTH-1:0]      data_q, data_d;

        // Next state: IDLE latches an offered write, HOLD always drains it.
        always_comb begin
            state_d = state_q;
            addr_d  = addr_q;
            data_d  = data_q;
            case (state_q)
                ST_IDLE: begin
                    if (wr_valid) begin
                        state_d = ST_HOLD;
                        addr_d  = wr_addr;
                        data_d  = wr_data;
                    end
                end
                ST_HOLD: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end

        // State register; reset drops any pending write.
        always_ff @(posedge clk) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            if (reset) begin
                state_q <= ST_IDLE;
            end else begin
                state_q <= state_d;
            end
        end

        // Buffered payload, meaningful only while state_q is HOLD.
        always_ff @(posedge clk) begin
            // NOTE: payload has no reset; state_q alone decides whether it is used.
            addr_q <= addr_d;
            data_q <= data_d;
        end

        // Ready and busy are decodes of the state flop, so wr_ready has no
        // combinational dependence on wr_valid.
        assign wr_ready     = (state_q == ST_IDLE);
        assign busy         = (state_q == ST_HOLD);
        assign commit_valid = (state_q == ST_HOLD);
        assign commit_addr  = addr_q;
        assign commit_data  = data_q;
    end else begin : g_direct
        assign wr_ready     = 1'b1;
        assign busy         = 1'b0;
        assign commit_valid = wr_valid;
        assign commit_addr  = wr_addr;
        assign commit_data  = wr_data;
    end

    decoder5to32 #(
        .ADDR_W (DEPTH_LOG2)
    ) u_dec (
        .addr_i   (commit_addr),
        .en_i     (commit_valid),
        .onehot_o (commit_onehot)
    );

    // Register array and enable pulse; the array must clear on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM; k++) begin
                regs_q[k] <= '0;
            end
            wr_enables_q <= '0;
        end else begin
            wr_enables_q <= commit_onehot;
            for (int k = 0; k < NUM; k++) begin
                if (commit_onehot[k]) begin
                    regs_q[k] <= commit_data;
                end
            end
        end
    end

    assign wr_enables = wr_enables_q;

    for (genvar k = 0; k < NUM; k++) begin : g_flat
        assign regs_flat[WIDTH*k +: WIDTH] = regs_q[k];
    end

endmodule

// File: doc/regfile_write_bank.md
Name: regfile_write_bank

Overview:
- Write side of the CPU register file. Decodes a 5-bit write address into 32 one-hot enables and holds the 32x32-bit register array.
- Exports the whole array as a flat 1024-bit bus that feeds the read-side 32:1 word selectors.
- Register 0 is hardwired to zero.
- An optional one-deep write buffer with a valid/ready handshake decouples the writeback producer.

Parameters:
- WIDTH, 32, bits per register.
- DEPTH_LOG2, 5, address width; 2**DEPTH_LOG2 registers.
- BUFFERED, 1, 1 = one-deep write skid buffer; 0 = write commits on the accepting edge.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- wr_valid  input  1  producer presents a write.
- wr_ready  output  1  block can accept a write this cycle.
- wr_addr  input  DEPTH_LOG2  destination register.
- wr_data  input  WIDTH  write data.
- wr_enables  output  2**DEPTH_LOG2  registered one-hot of the last committed write. Bit 0 never set. All zero in idle cycles.
- regs_flat  output  WIDTH*2**DEPTH_LOG2  register k occupies bits [WIDTH*k+WIDTH-1 : WIDTH*k].
- busy  output  1  a buffered write is pending.

Behaviour:
- Reset (synchronous, active-high, sampled on the clk edge):
  - Every register is 0, so regs_flat = 0.
  - wr_enables = 0, busy = 0, wr_ready = 1.
  - Any pending buffered write is discarded. reset wins over a same-cycle handshake.
- Accept: a write is accepted when wr_valid && wr_ready on a rising edge.
- BUFFERED=0:
  - wr_ready is tied to 1 (after reset).
  - The accepted write updates register wr_addr at that edge. regs_flat reflects it one cycle after the accepting edge (latency 1).
- BUFFERED=1 uses a two-state FSM, IDLE and HOLD:
  - IDLE: wr_ready = 1. On accept, latch addr/data and go to HOLD. busy = 1 from the next cycle.
  - HOLD: on the next edge, commit the latched write to the array, pulse wr_enables for one cycle, and return to IDLE. busy is cleared.
  - HOLD: wr_ready = 0. This is a registered ready, with no combinational path from wr_valid to wr_ready.
  - Latency from accepting edge to regs_flat update: 2 cycles. Sustained throughput: one write per 2 cycles.
- Decoder:
  - wr_enables[k] = 1 for exactly the cycle after the commit edge, with k = committed address.
  - Writes to address 0 complete the handshake, but wr_enables stays all zero and register 0 stays 0.
- Width rules:
  - wr_data is stored unmodified, with no sign handling.
  - Address decode uses the full DEPTH_LOG2 bits; no out-of-range case exists.
- Read-during-write: regs_flat is purely registered. A read-side mux sampling the same cycle as a commit edge sees the old value; no internal bypass. Forwarding is the pipeline's job.
- Back-to-back writes to the same address: the last committed write wins. Each commit produces its own wr_enables pulse.
- Inputs when wr_valid=0 are don't-care and must not change state.

Decomposition:
- Shared package holds: REG_WIDTH=32, REG_ADDR_W=5, NUM_REGS=32, ZERO_REG=0, and the FSM state encoding (IDLE=1'b0, HOLD=1'b1).
- One natural sub-module, decoder5to32. It is combinational, takes an address and an enable, produces a one-hot output, and forces bit 0 low. It mirrors the read-side selector and is reused by later units.
- The top instantiates the decoder and the array and generates the flat bus with a generate loop.

Test Plan:
- Reset with random pre-state, then reset deasserted -> regs_flat = 0, wr_ready = 1, busy = 0, wr_enables = 0.
- BUFFERED=1: write addr 5, data 0xDEADBEEF at cycle t -> wr_ready=0 and busy=1 at t+1. At t+2, regs_flat[191:160] = 0xDEADBEEF and wr_enables = 32'h0000_0020 for one cycle.
- Write addr 0, data 0xFFFFFFFF -> handshake completes, regs_flat[31:0] stays 0, wr_enables stays 0.
- wr_valid held high for 4 writes (addr 1..4, data 0x11..0x44) -> exactly one accept per 2 cycles. All four values appear in order. No write is lost or duplicated.
- Reset asserted in the cycle after accepting addr 7, data 0x1234 -> register 7 remains 0, busy = 0, wr_ready = 1 on the following cycle.
- BUFFERED=0: writes to addr 31 data 0xA5A5A5A5 then addr 31 data 0x5A5A5A5A on consecutive cycles -> regs_flat[1023:992] shows 0xA5A5A5A5 and then 0x5A5A5A5A. wr_enables bit 31 is high for both cycles.
